// File: rtl/sdram_pkg.sv
// Shared SDRAM definitions: default user-port widths and arbiter state encoding.
package sdram_pkg;

    localparam int unsigned SdramAddrWidth = 22;
    localparam int unsigned SdramDataWidth = 16;

    typedef enum logic [1:0] {
        IDLE,
        ISSUE,
        WAIT_RD
    } arb_state_t;

endpackage

// File: rtl/sdram_arbiter_rr_pick.sv
// Combinational round-robin picker: first requester after `last`, wrapping modulo NumPorts.
module rr_pick #(
    parameter int unsigned NumPorts = 3
) (
    input  logic [NumPorts-1:0]         req_i,
    input  logic [$clog2(NumPorts)-1:0] last_i,
    output logic [NumPorts-1:0]         gnt_o,
    output logic [$clog2(NumPorts)-1:0] idx_o
);

    localparam int unsigned IdxW = $clog2(NumPorts);

    logic                found;
    logic [IdxW-1:0]     cand;

    always_comb begin
        gnt_o = '0;
        idx_o = '0;
        found = 1'b0;
        cand  = '0;
        for (int unsigned i = 1; i <= NumPorts; i++) begin
            cand = IdxW'((32'(last_i) + i) % NumPorts);
            if (!found && req_i[cand]) begin
                found        = 1'b1;
                gnt_o[cand]  = 1'b1;
                idx_o        = cand;
            end
        end
    end

endmodule

// File: rtl/sdram_arbiter.sv
// Round-robin arbiter sharing the sdram_ctrl user port; one transaction in flight, read watchdog.
module sdram_arbiter
    import sdram_pkg::*;
#(
    parameter int unsigned NumPorts  = 3,
    parameter int unsigned AddrWidth = SdramAddrWidth,
    parameter int unsigned DataWidth = SdramDataWidth,
    parameter int unsigned RdTimeout = 64
) (
    input  logic                          i_dram_clk,
    input  logic                          i_rst,
    input  logic [NumPorts-1:0]           i_req,
    input  logic [NumPorts-1:0]           i_we,
    input  logic [NumPorts*AddrWidth-1:0] i_addr,
    input  logic [NumPorts*DataWidth-1:0] i_wdata,
    output logic [NumPorts-1:0]           o_gnt,
    output logic [NumPorts-1:0]           o_rvalid,
    output logic [DataWidth-1:0]          o_rdata,
    output logic                          o_err,
    output logic                          o_ctrl_wr_req,
    output logic                          o_ctrl_rd_req,
    output logic [AddrWidth-1:0]          o_ctrl_addr,
    output logic [DataWidth-1:0]          o_ctrl_wdata,
    input  logic                          i_ctrl_ack,
    input  logic                          i_ctrl_rd_rdy,
    input  logic [DataWidth-1:0]          i_ctrl_rd_data
);

    localparam int unsigned IdxW = $clog2(NumPorts);
    localparam int unsigned CntW = $clog2(RdTimeout);
    localparam logic [CntW-1:0] CntLast = CntW'(RdTimeout - 1);

    arb_state_t           state_q;
    logic [IdxW-1:0]      last_q;
    logic [IdxW-1:0]      pick_idx;
    logic [NumPorts-1:0]  pick_gnt;
    logic [NumPorts-1:0]  owner_q;
    logic [NumPorts-1:0]  gnt_q;
    logic [NumPorts-1:0]  rvalid_q;
    logic                 we_q;
    logic                 wr_req_q;
    logic                 rd_req_q;
    logic                 err_q;
    logic [AddrWidth-1:0] addr_q;
    logic [DataWidth-1:0] wdata_q;
    logic [DataWidth-1:0] rdata_q;
    logic [CntW-1:0]      cnt_q;

    rr_pick #(
        .NumPorts(NumPorts)
    ) u_pick (
        .req_i  (i_req),
        .last_i (last_q),
        .gnt_o  (pick_gnt),
        .idx_o  (pick_idx)
    );

    always_ff @(posedge i_dram_clk) begin
        if (i_rst) begin
            state_q  <= IDLE;
            last_q   <= IdxW'(NumPorts - 1);
            owner_q  <= '0;
            we_q     <= 1'b0;
            addr_q   <= '0;
            wdata_q  <= '0;
            rdata_q  <= '0;
            gnt_q    <= '0;
            rvalid_q <= '0;
            err_q    <= 1'b0;
            wr_req_q <= 1'b0;
            rd_req_q <= 1'b0;
            cnt_q    <= '0;
        end else begin
            gnt_q    <= '0;
            rvalid_q <= '0;
            err_q    <= 1'b0;
            unique case (state_q)
                IDLE: begin
                    if (|i_req) begin
                        we_q     <= i_we[pick_idx];
                        addr_q   <= i_addr[pick_idx*AddrWidth +: AddrWidth];
                        wdata_q  <= i_wdata[pick_idx*DataWidth +: DataWidth];
                        owner_q  <= pick_gnt;
                        last_q   <= pick_idx;
                        gnt_q    <= pick_gnt;
                        wr_req_q <= i_we[pick_idx];
                        rd_req_q <= ~i_we[pick_idx];
                        state_q  <= ISSUE;
                    end
                end
                // No timeout here: refreshes may hold off acceptance indefinitely.
                ISSUE: begin
                    if (i_ctrl_ack) begin
                        wr_req_q <= 1'b0;
                        rd_req_q <= 1'b0;
                        cnt_q    <= '0;
                        state_q  <= we_q ? IDLE : WAIT_RD;
                    end
                end
                WAIT_RD: begin
                    if (i_ctrl_rd_rdy) begin
                        rdata_q  <= i_ctrl_rd_data;
                        rvalid_q <= owner_q;
                        state_q  <= IDLE;
                    end else if (cnt_q == CntLast) begin
                        err_q   <= 1'b1;
                        state_q <= IDLE;
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign o_gnt         = gnt_q;
    assign o_rvalid      = rvalid_q;
    assign o_rdata       = rdata_q;
    assign o_err         = err_q;
    assign o_ctrl_wr_req = wr_req_q;
    assign o_ctrl_rd_req = rd_req_q;
    assign o_ctrl_addr   = addr_q;
    assign o_ctrl_wdata  = wdata_q;

endmodule

// File: tb/tb_sdram_arbiter.sv
// Directed self-checking bench for sdram_arbiter with hand-computed expectations.
module tb_sdram_arbiter;

    localparam int unsigned NP = 3;
    localparam int unsigned AW = 22;
    localparam int unsigned DW = 16;

    logic             clk = 1'b0;
    logic             rst;
    logic [NP-1:0]    req, we;
    logic [NP*AW-1:0] addr;
    logic [NP*DW-1:0] wdata;
    logic [NP-1:0]    gnt, rvalid;
    logic [DW-1:0]    rdata;
    logic             err, wr_req, rd_req;
    logic [AW-1:0]    c_addr;
    logic [DW-1:0]    c_wdata;
    logic             ack, rd_rdy;
    logic [DW-1:0]    rd_data;

    int checks = 0;
    int errors = 0;

    sdram_arbiter #(
        .NumPorts (NP),
        .AddrWidth(AW),
        .DataWidth(DW),
        .RdTimeout(64)
    ) dut (
        .i_dram_clk    (clk),
        .i_rst         (rst),
        .i_req         (req),
        .i_we          (we),
        .i_addr        (addr),
        .i_wdata       (wdata),
        .o_gnt         (gnt),
        .o_rvalid      (rvalid),
        .o_rdata       (rdata),
        .o_err         (err),
        .o_ctrl_wr_req (wr_req),
        .o_ctrl_rd_req (rd_req),
        .o_ctrl_addr   (c_addr),
        .o_ctrl_wdata  (c_wdata),
        .i_ctrl_ack    (ack),
        .i_ctrl_rd_rdy (rd_rdy),
        .i_ctrl_rd_data(rd_data)
    );

    always #5 clk = ~clk;

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "time limit");
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0h exp %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_outs"}, {gnt, rvalid, err, wr_req, rd_req}, 32'h0);
        check({tag, "_rdata"}, 32'(rdata), 32'h0);
        check({tag, "_addr"}, 32'(c_addr), 32'h0);
        check({tag, "_wdata"}, 32'(c_wdata), 32'h0);
    endtask

    int unsigned n;
    logic        seen;
    logic [NP-1:0] prev;

    initial begin
        rst = 1'b1; req = '0; we = '0; addr = '0; wdata = '0;
        ack = 1'b0; rd_rdy = 1'b0; rd_data = '0;
        tick(); tick();
        rst = 1'b0;
        check_all_zero("reset");

        // Single write from port 1
        req = 3'b010; we = 3'b010;
        addr[1*AW +: AW] = 22'h012345;
        wdata[1*DW +: DW] = 16'hBEEF;
        tick();
        check("wr_gnt", 32'(gnt), 32'b010);
        check("wr_req", {wr_req, rd_req}, 32'b10);
        check("wr_addr", 32'(c_addr), 32'h012345);
        check("wr_data", 32'(c_wdata), 32'hBEEF);
        req = '0;
        tick();
        check("wr_hold", {gnt, wr_req}, 32'b0001);
        ack = 1'b1;
        tick();
        ack = 1'b0;
        check("wr_drop", {wr_req, rd_req, rvalid}, 32'h0);

        // Spurious ack / rd_rdy in IDLE
        ack = 1'b1; rd_rdy = 1'b1; rd_data = 16'hFFFF;
        tick();
        ack = 1'b0; rd_rdy = 1'b0;
        check("spur_outs", {gnt, rvalid, err, wr_req, rd_req}, 32'h0);
        check("spur_rdata", 32'(rdata), 32'h0);
        tick();
        check("spur_quiet", {gnt, rvalid, err, wr_req, rd_req}, 32'h0);

        // Round-robin from reset: all three ports writing continuously
        rst = 1'b1; tick(); rst = 1'b0;
        req = 3'b111; we = 3'b111;
        prev = '0;
        for (int k = 0; k < 6; k++) begin
            n = 0; seen = 1'b0;
            while (!seen && n < 10) begin
                tick(); n++;
                if (gnt != '0) seen = 1'b1;
            end
            check("rr_seen", 32'(seen), 32'h1);
            check("rr_order", 32'(gnt), 32'(3'b001 << (k % 3)));
            check("rr_no_repeat", 32'(gnt == prev), 32'h0);
            prev = gnt;
            tick();
            ack = 1'b1;
            tick();
            ack = 1'b0;
            check("rr_drop", {wr_req, rd_req}, 32'h0);
        end
        req = '0;
        tick();

        // Read steering to port 2, ack delayed by a refresh
        req = 3'b100; we = 3'b000;
        addr[2*AW +: AW] = 22'h3ABCD;
        tick();
        check("rd_gnt", 32'(gnt), 32'b100);
        check("rd_req", {wr_req, rd_req}, 32'b01);
        check("rd_addr", 32'(c_addr), 32'h3ABCD);
        req = '0;
        repeat (4) tick();
        check("rd_hold", {wr_req, rd_req}, 32'b01);
        ack = 1'b1;
        tick();
        ack = 1'b0;
        check("rd_drop", {wr_req, rd_req}, 32'h0);
        repeat (5) tick();
        check("rd_wait", {rvalid, err}, 32'h0);
        rd_rdy = 1'b1; rd_data = 16'hA5A5;
        tick();
        rd_rdy = 1'b0; rd_data = 16'h0000;
        check("rd_rvalid", 32'(rvalid), 32'b100);
        check("rd_rdata", 32'(rdata), 32'hA5A5);
        tick();
        check("rd_pulse_end", 32'(rvalid), 32'h0);
        rd_rdy = 1'b1; rd_data = 16'h1234;
        tick();
        rd_rdy = 1'b0;
        check("rd_stale", 32'(rvalid), 32'h0);
        check("rd_stale_data", 32'(rdata), 32'hA5A5);

        // Timeout: port 0 reads with no data; port 1 write pending
        req = 3'b011; we = 3'b010;
        tick();
        check("to_gnt", 32'(gnt), 32'b001);
        check("to_rdreq", 32'(rd_req), 32'h1);
        req = 3'b010;
        ack = 1'b1;
        tick();
        ack = 1'b0;
        seen = 1'b0;
        repeat (63) begin
            tick();
            if (err || gnt != '0 || rvalid != '0) seen = 1'b1;
        end
        check("to_early", 32'(seen), 32'h0);
        tick();
        check("to_err", 32'(err), 32'h1);
        check("to_no_rvalid", {gnt, rvalid}, 32'h0);
        tick();
        check("to_err_end", 32'(err), 32'h0);
        check("to_next_gnt", 32'(gnt), 32'b010);
        check("to_next_wr", 32'(wr_req), 32'h1);
        req = '0;
        ack = 1'b1;
        tick();
        ack = 1'b0;

        // Reset in the middle of a read from port 1
        req = 3'b010; we = 3'b000;
        tick();
        check("mr_gnt", 32'(gnt), 32'b010);
        req = '0;
        ack = 1'b1;
        tick();
        ack = 1'b0;
        tick(); tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check_all_zero("mr_reset");
        rd_rdy = 1'b1; rd_data = 16'hBBBB;
        tick();
        rd_rdy = 1'b0;
        check("mr_late", 32'(rvalid), 32'h0);
        check("mr_late_data", 32'(rdata), 32'h0);
        req = 3'b111; we = 3'b000;
        tick();
        check("mr_first", 32'(gnt), 32'b001);
        req = '0;
        tick();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/sdram_arbiter.md
# sdram_arbiter

Round-robin arbiter that shares the single read/write user port of `sdram_ctrl` between `NumPorts` requesters (e.g. CPU, video fetch, DMA). It keeps at most one transaction in flight and holds the controller request until the controller accepts it. Read data is steered back to the requester that owns the transaction, and a watchdog recovers from a read that never completes. The block sits between the client logic and `sdram_ctrl`, in the DRAM clock domain.

## Interface
- `NumPorts`, 3: number of requesters, 2..4.
- `AddrWidth`, 22: `{bank, col, row}` address width; matches `sdram_ctrl` user address.
- `DataWidth`, 16: data word width.
- `RdTimeout`, 64: maximum cycles spent in WAIT_RD before aborting.

Ports:
- `i_dram_clk`  in  1  clock. This is the single clock; everything runs on its rising edge.
- `i_rst`  in  1  reset. Synchronous, active-high.
- `i_req`  in  NumPorts  per-port request. Held by the client until it sees `o_gnt`.
- `i_we`  in  NumPorts  per-port direction: 1 = write, 0 = read.
- `i_addr`  in  NumPorts*AddrWidth  flattened per-port address; port p is at slice `[p*AddrWidth +: AddrWidth]`.
- `i_wdata`  in  NumPorts*DataWidth  flattened per-port write data.
- `o_gnt`  out  NumPorts  one-hot, one-cycle pulse. It means the command has been captured, and the client may drop or change its request.
- `o_rvalid`  out  NumPorts  one-hot, one-cycle pulse marking read data valid for the owning port.
- `o_rdata`  out  DataWidth  read data. Valid only while `o_rvalid` is nonzero.
- `o_err`  out  1  one-cycle pulse on read timeout.
- `o_ctrl_wr_req`, `o_ctrl_rd_req`  out  1 each  request to `sdram_ctrl`.
- `o_ctrl_addr`  out  AddrWidth  address to `sdram_ctrl`. It drives both `i_wr_addr` and `i_rd_addr`.
- `o_ctrl_wdata`  out  DataWidth  write data to `sdram_ctrl`.
- `i_ctrl_ack`  in  1  one-cycle pulse from `sdram_ctrl` on the cycle it leaves RDY_NOP to start the requested access. A refresh does not produce an ack.
- `i_ctrl_rd_rdy`  in  1  `sdram_ctrl` `o_rd_rdy`.
- `i_ctrl_rd_data`  in  DataWidth  `sdram_ctrl` `o_rd_data`.

## Operation
- The state machine has three states: IDLE, ISSUE and WAIT_RD. Reset drives the state to IDLE.
- **IDLE:**
  - If `i_req` is nonzero, pick the winner w. The search is round-robin, starting at `last+1` modulo NumPorts.
  - Capture w's `i_we`, `i_addr` and `i_wdata`, and record w as the owner.
  - Update `last` to w, pulse `o_gnt[w]`, then go to ISSUE.
- **ISSUE:**
  - Hold `o_ctrl_wr_req` (if the captured `we` = 1) or `o_ctrl_rd_req` (if `we` = 0) asserted, with the captured address and data, until `i_ctrl_ack`.
  - There is no timeout in this state, because refreshes may delay acceptance indefinitely.
  - On `i_ctrl_ack` for a write: go to IDLE.
  - On `i_ctrl_ack` for a read: clear the watchdog counter and go to WAIT_RD.
- **WAIT_RD:**
  - On `i_ctrl_rd_rdy`: register `i_ctrl_rd_data` into `o_rdata`, pulse `o_rvalid[owner]`, and go to IDLE.
  - Otherwise, if the counter equals `RdTimeout-1`: pulse `o_err` and go to IDLE, with no `o_rvalid`.
  - Otherwise, increment the counter.
- `i_ctrl_rd_rdy` outside WAIT_RD (stale or spurious) is ignored.
- `i_ctrl_ack` outside ISSUE is ignored.
- Requests arriving while the state is not IDLE wait; they are never dropped by the arbiter.
- Reset values:
  - `last` = NumPorts-1, so port 0 wins first after reset.
  - All outputs are 0, including `o_rdata`.
  - The watchdog counter is 0.
- **Reset mid-operation:** the controller request drops on the next edge and the state returns to IDLE. A late `i_ctrl_rd_rdy` is then ignored.
- The watchdog counter is `$clog2(RdTimeout)` bits wide; it never wraps within WAIT_RD.

## Timing
- **Grant:** if `i_req[w]` is sampled high in IDLE at edge T, then `o_gnt[w]` = 1 and the controller request = 1 during cycle T+1.
- **Request drop:** if ack is sampled at edge A, the controller request is 0 from A+1.
- **Write turnaround:** the earliest next grant is at edge A+2. Minimum per-write occupancy is 3 cycles.
- **Read data:** if `i_ctrl_rd_rdy` is sampled at edge R, then `o_rvalid`/`o_rdata` are valid during cycle R+1. This is exactly one cycle of read-data latency added by the arbiter.
- **Back-to-back:** IDLE is re-entered for at least one cycle between transactions.
- **Timeout:** `o_err` is high during the cycle following the `RdTimeout`th WAIT_RD cycle.

## Structure
- Shared package `sdram_pkg` holds:
  - `arb_state_t` (IDLE/ISSUE/WAIT_RD);
  - the default address and data widths, shared with `sdram_ctrl`.
- One sub-module, `rr_pick`: a combinational round-robin picker. Inputs are `req[NumPorts]` and `last`; outputs are one-hot `gnt` and index `idx`. It has no registers.
- All state, capture registers, `last` and the watchdog live in `sdram_arbiter`.

## Test plan
- **Single write, port 1:** `addr`=0x0_12_345, `wdata`=0xBEEF. Expect `o_gnt`=0b010 one cycle after the request; `o_ctrl_wr_req` high with those values until ack; request low the cycle after ack; no `o_rvalid`.
- **Round-robin:** all three ports request writes continuously from reset, with ack 2 cycles after each request. Expect the grant order 0,1,2,0,1,2 and no port granted twice in a row.
- **Read steering:** port 2 reads. Ack after 5 cycles (simulating a refresh first), then `rd_rdy` 6 cycles later with data 0xA5A5. Expect `o_rvalid`=0b100 and `o_rdata`=0xA5A5 for one cycle, the cycle after `rd_rdy`.
- **Timeout:** a read is acked but `rd_rdy` never arrives. Expect `o_err` pulse after 64 WAIT_RD cycles, a return to IDLE, and the next pending request granted.
- **Reset mid-read:** assert `i_rst` for one cycle in WAIT_RD. Expect all outputs 0 next cycle. A subsequent `rd_rdy` pulse produces no `o_rvalid`. After reset, port 0 wins first.
- **Spurious inputs:** `i_ctrl_ack`/`i_ctrl_rd_rdy` pulsed in IDLE. Expect no state change and no output pulses.
